// File: rtl/pwm_multi_core_if.sv
// rtl/pwm_multi_core_if.sv - byte-wide register bus between the SPI front ends and the PWM engine
interface pwm_multi_core_if;
    logic [7:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;

    modport master (
        output addr,
        output wr_en,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/pwm_multi_core.sv
// rtl/pwm_multi_core.sv - multi-channel double-buffered PWM engine with byte register bus
module pwm_multi_core #(
    parameter int         NCH      = 4,
    parameter int         CW       = 16,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_multi_core_if.slave     bus,
    input  logic                sync_start,
    output logic [NCH-1:0]      pwm_out,
    output logic                irq
);
    localparam int NB = CW / 8;

    logic [NCH-1:0] en;
    logic [NCH-1:0] pol;
    logic [NCH-1:0] status;
    logic [NCH-1:0] irq_mask;
    logic [NCH-1:0] wrap;
    logic [NCH-1:0] w1c;
    logic [CW-1:0]  stg_high   [NCH];
    logic [CW-1:0]  stg_period [NCH];

    // Channel window: 0x10 + 8*c, so addr[7:3] - 2 is the channel number.
    logic [4:0] slot;
    logic       ch_hit;
    logic [7:0] rd_mux;

    assign slot   = bus.addr[7:3] - 5'd2;
    assign ch_hit = (bus.addr[7:3] >= 5'd2) && (int'(slot) < NCH);
    assign w1c    = (bus.wr_en && bus.addr == 8'h03) ? bus.wr_data[NCH-1:0] : '0;
    assign irq    = |(status & irq_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= '0;
            pol      <= '0;
            status   <= '0;
            irq_mask <= '0;
            for (int c = 0; c < NCH; c++) begin
                stg_high[c]   <= '0;
                stg_period[c] <= '0;
            end
        end else begin
            // A wrap on the same edge as a clear keeps the bit set.
            status <= (status & ~w1c) | wrap;
            if (bus.wr_en) begin
                case (bus.addr)
                    8'h01:   en       <= bus.wr_data[NCH-1:0];
                    8'h02:   pol      <= bus.wr_data[NCH-1:0];
                    8'h04:   irq_mask <= bus.wr_data[NCH-1:0];
                    default: ;
                endcase
                for (int c = 0; c < NCH; c++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (ch_hit && slot == 5'(c) && int'(bus.addr[1:0]) == b) begin
                            if (bus.addr[2])
                                stg_period[c][8*b +: 8] <= bus.wr_data;
                            else
                                stg_high[c][8*b +: 8] <= bus.wr_data;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            8'h00:   rd_mux = ID_VALUE;
            8'h01:   rd_mux[NCH-1:0] = en;
            8'h02:   rd_mux[NCH-1:0] = pol;
            8'h03:   rd_mux[NCH-1:0] = status;
            8'h04:   rd_mux[NCH-1:0] = irq_mask;
            default: begin
                for (int c = 0; c < NCH; c++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (ch_hit && slot == 5'(c) && int'(bus.addr[1:0]) == b)
                            rd_mux = bus.addr[2] ? stg_period[c][8*b +: 8]
                                                 : stg_high[c][8*b +: 8];
                    end
                end
            end
        endcase
    end

    assign bus.rd_data = rd_mux;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] act_high;
        logic [CW-1:0] act_period;
        logic          en_d;
        logic          pwm_q;
        logic          load;
        logic          wrap_c;
        logic          raw;

        // en_d gates the output so the enable cycle never shows stale active values.
        assign load   = en[c] & (~en_d | sync_start);
        assign wrap_c = en[c] & en_d & ~sync_start & (act_period != '0)
                      & (cnt == act_period - 1'b1);
        assign raw    = (act_period != '0) & (cnt < act_high);
        assign wrap[c]    = wrap_c;
        assign pwm_out[c] = pwm_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt        <= '0;
                act_high   <= '0;
                act_period <= '0;
                en_d       <= 1'b0;
                pwm_q      <= 1'b0;
            end else begin
                en_d  <= en[c];
                pwm_q <= (raw & en[c] & en_d) ^ pol[c];
                if (!en[c]) begin
                    cnt <= '0;
                end else if (load || wrap_c) begin
                    cnt        <= '0;
                    act_high   <= stg_high[c];
                    act_period <= stg_period[c];
                end else if (act_period == '0) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi_core.sv
// tb/tb_pwm_multi_core.sv - self-checking bench for pwm_multi_core
module tb_pwm_multi_core;
    logic       clk;
    logic       rst_n;
    logic       sync_start;
    logic [3:0] pwm_out;
    logic       irq;

    pwm_multi_core_if bus();

    pwm_multi_core #(.NCH(4), .CW(16), .ID_VALUE(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sync_start (sync_start),
        .pwm_out    (pwm_out),
        .irq        (irq)
    );

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q [$];
    logic [7:0] rd_q  [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rd_data, rd_q.pop_front());
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
    endtask

    task automatic run_const(input string tag, input int n, input logic [4:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s%0d", tag, i), {irq, pwm_out}, exp_q.pop_front());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        sync_start  = 1'b0;
        bus.addr    = 8'h00;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pwm", {irq, pwm_out}, 5'b0);
        rst_n = 1'b1;
        @(negedge clk);

        rd_chk("id", 8'h00, 8'hA5);
        for (int a = 1; a <= 4; a++) rd_chk($sformatf("reg%0d", a), 8'(a), 8'h00);
        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 8; o++)
                rd_chk($sformatf("ch%0d_%0d", c, o), 8'(8'h10 + 8*c + o), 8'h00);

        wr(8'h01, 8'hF5); rd_chk("en_mask", 8'h01, 8'h05);
        wr(8'h01, 8'h00);
        wr(8'h05, 8'hFF); rd_chk("unlisted", 8'h05, 8'h00);
        wr(8'h11, 8'hAB); rd_chk("hi_b1", 8'h11, 8'hAB);
        wr(8'h12, 8'h55); rd_chk("hi_b2", 8'h12, 8'h00);
        wr(8'h11, 8'h00);
        wr(8'h2C, 8'h3C); rd_chk("ch3_per", 8'h2C, 8'h3C);
        wr(8'h30, 8'h77); rd_chk("no_ch4", 8'h30, 8'h00);

        // Basic waveform, double buffering, W1C and the wrap/W1C race in one timeline.
        wr(8'h10, 8'd3);
        wr(8'h14, 8'd10);
        wr(8'h04, 8'h01);
        for (int k = 0; k < 76; k++) begin
            int  j;
            int  h;
            logic p;
            logic s;
            j = k - 2;
            h = (j >= 30) ? 7 : 3;
            p = (k >= 2) && ((j % 10) < h);
            s = (k >= 11) && !(k >= 56 && k < 61);
            exp_q.push_back({s && (k < 74), 3'b000, p});
        end
        for (int k = 0; k < 76; k++) begin
            bus.wr_en = 1'b0;
            case (k)
                0:       drive(8'h01, 8'h01);
                25:      drive(8'h10, 8'd7);
                56:      drive(8'h03, 8'h01);
                71:      drive(8'h03, 8'h01);
                74:      drive(8'h04, 8'h00);
                default: ;
            endcase
            @(negedge clk);
            chk($sformatf("A%0d", k), {irq, pwm_out}, exp_q.pop_front());
        end
        bus.wr_en = 1'b0;
        rd_chk("st_sticky", 8'h03, 8'h01);

        // Boundaries on channel 0.
        wr(8'h01, 8'h00);
        wr(8'h10, 8'd3);
        wr(8'h14, 8'd0);
        wr(8'h03, 8'h01);
        wr(8'h01, 8'h01);
        @(negedge clk);
        run_const("P0_", 20, 5'b00000);
        rd_chk("st_p0", 8'h03, 8'h00);

        wr(8'h01, 8'h00);
        wr(8'h10, 8'd0);
        wr(8'h14, 8'd10);
        wr(8'h01, 8'h01);
        @(negedge clk);
        run_const("H0_", 20, 5'b00000);

        wr(8'h01, 8'h00);
        wr(8'h10, 8'd12);
        wr(8'h01, 8'h01);
        @(negedge clk);
        run_const("H12_", 20, 5'b00001);

        wr(8'h01, 8'h00);
        wr(8'h02, 8'h01);
        @(negedge clk);
        run_const("POL_", 10, 5'b00001);
        wr(8'h02, 8'h00);

        // Two channels with different periods, enabled apart, then realigned.
        wr(8'h01, 8'h00);
        wr(8'h10, 8'd3);
        wr(8'h14, 8'd10);
        wr(8'h18, 8'd5);
        wr(8'h1C, 8'd15);
        wr(8'h01, 8'h01);
        repeat (4) @(negedge clk);
        wr(8'h01, 8'h03);
        repeat (7) @(negedge clk);
        for (int k = 1; k <= 30; k++) begin
            logic p0;
            logic p1;
            p0 = ((k - 1) % 10) < 3;
            p1 = ((k - 1) % 15) < 5;
            exp_q.push_back({3'b000, p1, p0});
        end
        sync_start = 1'b1;
        @(negedge clk);
        sync_start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk($sformatf("S%0d", k), {irq, pwm_out}, exp_q.pop_front());
        end

        // Asynchronous reset while running with an inverted channel.
        wr(8'h02, 8'h04);
        @(negedge clk);
        chk("pol_pre", {1'b0, pwm_out[2]}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pwm", {irq, pwm_out}, 5'b0);
        rd_chk("arst_en", 8'h01, 8'h00);
        rd_chk("arst_pol", 8'h02, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi_core.md
# pwm_multi_core

Register-mapped, multi-channel PWM engine that replaces the single-channel PWM generator and its hand-coded register block behind the SPI front ends. It exposes a byte-wide register bus driven by the SPI slaves. Channel count and counter width are parameters. Each channel has double-buffered duty and period registers, polarity control, a sticky period-done status and an external phase-align input.

## Interface
- `NCH`, 4: number of PWM channels, 1..8.
- `CW`, 16: counter width in bits, one of 8/16/24/32; `NB = CW/8` bytes per value.
- `ID_VALUE`, 8'hA5: value of the read-only ID register.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `addr` input 8: register byte address.
- `wr_en` input 1: single-cycle write strobe; `wr_data` is captured on the rising edge.
- `wr_data` input 8: write data.
- `rd_data` output 8: combinational read data for `addr`.
- `sync_start` input 1: synchronous pulse that restarts all enabled channels in phase.
- `pwm_out` output NCH: registered PWM outputs.
- `irq` output 1: OR of all `status & irq_mask` bits.

## Operation
- Address map (unlisted addresses read 0, writes ignored):
  - 0x00 ID: read-only, returns `ID_VALUE`.
  - 0x01 EN: bit c enables channel c.
  - 0x02 POL: bit c inverts `pwm_out[c]`.
  - 0x03 STATUS: bit c is sticky period-done; write-1-to-clear.
  - 0x04 IRQ_MASK.
  - Channel c base = 0x10 + 8·c:
    - offsets 0..NB-1 hold staged HIGH, LSB first.
    - offsets 4..4+NB-1 hold staged PERIOD.
    - Bytes at or above NB within either field are unimplemented.
- Bits at or above NCH in EN/POL/STATUS/IRQ_MASK read 0 and ignore writes.
- All register reset values are 0.
- Per channel, staged HIGH/PERIOD are writable at any time and read back the staged value. The active copies are internal.
- Active copies load from staged:
  - when the channel is enabled and its counter wraps (`cnt == act_period-1`);
  - on the disabled→enabled transition;
  - on `sync_start` for an enabled channel.
  - Mid-period writes therefore never glitch the output.
- Counter `cnt` (CW bits):
  - Disabled: held at 0.
  - Enabled: counts 0..act_period-1 then wraps to 0.
  - `act_period == 0`: `cnt` held at 0, raw output inactive, no wrap, no status.
- Raw output = (`cnt < act_high`).
  - `act_high == 0` → always inactive.
  - `act_high >= act_period` (period≠0) → always active.
  - Comparisons are unsigned, CW bits.
- `pwm_out[c]` = registered(raw & en) ^ POL[c]. A disabled channel drives POL[c].
- STATUS[c] sets on every wrap of channel c.
  - If a wrap coincides with a W1C write to that bit, set wins.
- `sync_start` while enabled forces `cnt` to 0 and reloads active values. It does not set STATUS. It has no effect on disabled channels.
- A write to EN that disables a channel forces `cnt` to 0 on the next edge. Active values are retained until the next enable.
- Reset mid-operation: all registers, counters and outputs clear immediately (asynchronous). `pwm_out` goes to 0, because POL resets to 0.

## Timing
- Register write: visible on `rd_data` the cycle after the `wr_en` edge.
- Enable latency: EN write at edge E. At edge E+1, `cnt=0` and the active copies load. At edge E+2, `pwm_out` reflects `cnt=0`.
  - Thereafter `pwm_out` lags `cnt` by exactly one cycle.
- Period: exactly `act_period` clk cycles. High time: exactly min(`act_high`, `act_period`) cycles.
- Staged update: takes effect for the period that begins after the next wrap. Latency is at most `act_period` cycles.
- `sync_start` at edge S: `cnt=0` at S. Output reflects the new phase at S+1. All enabled channels stay phase-aligned.
- `irq` is combinational from registered STATUS/IRQ_MASK. There is no extra latency.

## Test plan
- Reset then read-back: read 0x00 → 0xA5. Read EN/POL/STATUS and all channel bytes → 0. `pwm_out` = 0.
- Ch0 basic: HIGH=3, PERIOD=10, EN=0x01 → `pwm_out[0]` pattern 3 high / 7 low, repeating every 10 cycles. STATUS[0] sets 10 cycles after the first `cnt=0`.
- Double buffering: mid-period write HIGH=7 → current period is still 3 high. The next period is 7 high, with no glitch between.
- Boundaries on one channel:
  - PERIOD=0 → constant low, STATUS never sets.
  - HIGH=0 → constant low.
  - HIGH=12, PERIOD=10 → constant high.
  - POL=1 with EN=0 → constant high.
- Multi-channel sync: ch0 period 10 and ch1 period 15, both enabled at different times, then `sync_start` pulse → both rising edges align on the cycle after the pulse.
- STATUS W1C race: write 0x01 to 0x03 on the same edge as a ch0 wrap → bit stays 1. A later W1C with no wrap → 0. `irq` follows IRQ_MASK.
